prio_arbiter: RTL and testbench

PRIO_ARBITER -- requirements
Module: prio_arbiter

---
 rtl/prio_arb_pkg.sv | 16 +
 rtl/prio_arb_enc.sv | 26 ++
 rtl/prio_arbiter.sv | 156 +++++++++++++++
 tb/tb_prio_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/prio_arb_pkg.sv
// Shared definitions for the prio_arbiter block.
//   state_t   : arbiter FSM state (IDLE, GRANT, GAP)
//   IDLE_CODE : value driven on gnt_code whenever no grant is held
//   IDX_W     : width of a requester index (16 requesters)
package prio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] IDLE_CODE = 8'hF0;
    localparam int         IDX_W     = 4;

endpackage

// File: rtl/prio_arb_enc.sv
// Combinational 16-to-4 priority encoder, highest set index wins.
// Ports:
//   req   : request vector (bit 15 has highest priority)
//   idx   : index of the highest set bit (0 when req is zero)
//   valid : high when any bit of req is set
module prio_arb_enc
    import prio_arb_pkg::*;
(
    input  logic [(1<<IDX_W)-1:0] req,
    output logic [IDX_W-1:0]      idx,
    output logic                  valid
);

    // Ascending scan: the last set bit seen is the highest index.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < (1 << IDX_W); i++) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// 16-requester arbiter with a bounded grant hold time.
// A winner is picked only in IDLE, holds the grant while its request stays
// high for at most MAX_HOLD cycles, then a one-cycle GAP precedes the next
// arbitration. All outputs are registered (grant appears one edge after the
// request is sampled).
//
// Build option:
//   PRIO_ARB_ROUND_ROBIN_EN defined   : round-robin; search starts at
//                                       last_idx-1 and descends with wrap.
//   PRIO_ARB_ROUND_ROBIN_EN undefined : fixed priority, highest index wins.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active-high
//   req       : level-sensitive request lines
//   gnt       : one-hot grant, zero when no grant
//   gnt_code  : granted index in [3:0], 8'hF0 when no grant
//   gnt_valid : high while a grant is held
//   timeout   : one-cycle pulse when a grant is revoked by MAX_HOLD
//   state_dbg : current FSM state, for observation only
module prio_arbiter
    import prio_arb_pkg::*;
#(
    parameter int N_REQ    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [7:0]       gnt_code,
    output logic             gnt_valid,
    output logic             timeout,
    output logic [1:0]       state_dbg
);

    localparam logic [IDX_W-1:0] HOLD_LIM = IDX_W'(MAX_HOLD);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] win_idx, win_nxt;
    logic [IDX_W-1:0] hold_cnt, hold_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [7:0]       code_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;

    logic [N_REQ-1:0] req_rot;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_valid;
    logic [IDX_W-1:0] winner;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   last_idx, last_nxt;
    logic [2*N_REQ-1:0] req_dbl;

    // Rotate right by last_idx so req[last_idx-1] lands on bit 15 (top
    // priority) and req[last_idx] on bit 0 (lowest); add offset back after.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[last_idx +: N_REQ];
    assign winner  = enc_idx + last_idx;
`else
    assign req_rot = req;
    assign winner  = enc_idx;
`endif

    prio_arb_enc u_enc (
        .req   (req_rot),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    assign state_dbg = state;

    always_comb begin
        state_nxt   = state;
        win_nxt     = win_idx;
        hold_nxt    = hold_cnt;
        gnt_nxt     = '0;
        code_nxt    = IDLE_CODE;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        last_nxt    = last_idx;
`endif
        case (state)
            IDLE: begin
                if (enc_valid) begin
                    state_nxt = GRANT;
                    win_nxt   = winner;
                    hold_nxt  = IDX_W'(1);
                    gnt_nxt   = ONE_HOT0 << winner;
                    code_nxt  = {{(8-IDX_W){1'b0}}, winner};
                    valid_nxt = 1'b1;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                    last_nxt  = winner;
`endif
                end
            end
            GRANT: begin
                // Only the winner's own line matters here; other requests
                // wait until IDLE.
                if (!req[win_idx]) begin
                    state_nxt = GAP;
                    hold_nxt  = '0;
                end else if (hold_cnt == HOLD_LIM) begin
                    state_nxt   = GAP;
                    hold_nxt    = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    hold_nxt  = hold_cnt + IDX_W'(1);
                    gnt_nxt   = gnt;
                    code_nxt  = gnt_code;
                    valid_nxt = 1'b1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            win_idx   <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_code  <= IDLE_CODE;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            win_idx   <= win_nxt;
            hold_cnt  <= hold_nxt;
            gnt       <= gnt_nxt;
            gnt_code  <= code_nxt;
            gnt_valid <= valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_idx <= '0;
        end else begin
            last_idx <= last_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed self-checking bench for prio_arbiter (MAX_HOLD = 8).
// Expected grant codes are written by hand; gnt and gnt_valid are derived
// from the expected code. Round-robin expectations follow the build macro.
module tb_prio_arbiter;
    import prio_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic [15:0] gnt;
    logic [7:0]  gnt_code;
    logic        gnt_valid;
    logic        timeout;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];

    prio_arbiter #(.N_REQ(16), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_code  (gnt_code),
        .gnt_valid (gnt_valid),
        .timeout   (timeout),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks all outputs against an expected code and timeout level.
    task automatic check_out(input string tag, input logic [7:0] exp_code,
                             input logic exp_to);
        logic [15:0] exp_gnt;
        logic        exp_valid;
        exp_valid = (exp_code != 8'hF0);
        exp_gnt   = exp_valid ? (16'h0001 << exp_code[3:0]) : 16'h0000;
        check_val({tag, ".code"},  32'(gnt_code),  32'(exp_code));
        check_val({tag, ".gnt"},   32'(gnt),       32'(exp_gnt));
        check_val({tag, ".valid"}, 32'(gnt_valid), 32'(exp_valid));
        check_val({tag, ".to"},    32'(timeout),   32'(exp_to));
    endtask

    initial begin
        logic [7:0] c;
        rst = 1'b1;
        req = 16'h0000;
        tick();
        tick();
        check_out("reset", 8'hF0, 1'b0);
        check_val("reset.state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 5; i++) begin
            tick();
            check_out($sformatf("idle%0d", i), 8'hF0, 1'b0);
        end

        // 8001: 15 wins, release 15, then 0 granted after GAP + IDLE
        req = 16'h8001;
        tick(); check_out("p8001.g15", 8'h0F, 1'b0);
        req = 16'h0001;
        tick(); check_out("p8001.gap", 8'hF0, 1'b0);
        tick(); check_out("p8001.idle", 8'hF0, 1'b0);
        tick(); check_out("p8001.g0", 8'h00, 1'b0);
        req = 16'h0000;
        tick(); check_out("p8001.gap2", 8'hF0, 1'b0);
        tick(); check_out("p8001.idle2", 8'hF0, 1'b0);

        // Single requester 3 held: 8 cycles, timeout, GAP, IDLE, regrant
        req = 16'h0008;
        for (int k = 1; k <= 8; k++) begin
            tick(); check_out($sformatf("hold3.c%0d", k), 8'h03, 1'b0);
        end
        tick(); check_out("hold3.timeout", 8'hF0, 1'b1);
        tick(); check_out("hold3.idle", 8'hF0, 1'b0);
        tick(); check_out("hold3.regrant", 8'h03, 1'b0);
        req = 16'h0000;
        tick(); check_out("hold3.gap", 8'hF0, 1'b0);
        tick(); check_out("hold3.idle2", 8'hF0, 1'b0);

        // All requesting: rotation order (or always 15 with fixed priority)
        rst = 1'b1;
        #1;
        check_out("rst2", 8'hF0, 1'b0);
        tick();
        rst = 1'b0;
        for (int g = 0; g < 17; g++) begin
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            exp_q.push_back(8'((15 - g) & 15));
`else
            exp_q.push_back(8'h0F);
`endif
        end
        req = 16'hFFFF;
        for (int g = 0; g < 17; g++) begin
            c = exp_q.pop_front();
            for (int k = 1; k <= 8; k++) begin
                tick(); check_out($sformatf("all.g%0d.c%0d", g, k), c, 1'b0);
            end
            tick(); check_out($sformatf("all.g%0d.to", g), 8'hF0, 1'b1);
            tick(); check_out($sformatf("all.g%0d.idle", g), 8'hF0, 1'b0);
        end
        req = 16'h0000;
        tick(); check_out("all.quiet", 8'hF0, 1'b0);

        // Reset during 4th cycle of a grant to 7
        req = 16'h0080;
        for (int k = 1; k <= 4; k++) begin
            tick(); check_out($sformatf("rst7.c%0d", k), 8'h07, 1'b0);
        end
        #2;
        rst = 1'b1;
        #1;
        check_out("rst7.async", 8'hF0, 1'b0);
        check_val("rst7.state", 32'(state_dbg), 32'(IDLE));
        tick(); check_out("rst7.held", 8'hF0, 1'b0);
        rst = 1'b0;
        req = 16'h0000;
        tick(); check_out("rst7.after", 8'hF0, 1'b0);

        // Late request does not preempt an active grant
        req = 16'h0004;
        tick(); check_out("late.g2", 8'h02, 1'b0);
        req = 16'h0204;
        tick(); check_out("late.keep1", 8'h02, 1'b0);
        tick(); check_out("late.keep2", 8'h02, 1'b0);
        req = 16'h0200;
        tick(); check_out("late.gap", 8'hF0, 1'b0);
        tick(); check_out("late.idle", 8'hF0, 1'b0);
        tick(); check_out("late.g9", 8'h09, 1'b0);
        req = 16'h0000;
        tick(); check_out("late.gap2", 8'hF0, 1'b0);
        tick(); check_out("late.idle2", 8'hF0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
